// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback
// and decodes the datapath selects, ALU operation and gated write enables.
module multicycle_control_unit #(
  parameter int ENABLE_JAL  = 1,
  parameter int ENABLE_BGEU = 1
) (
  input  logic        clk,
  input  logic        areset,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        status_SF,
  input  logic        status_CF,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        memWrite,
  output logic        AdrSrc,
  output logic        illegal,
  output logic [1:0]  ResultSRC,
  output logic [1:0]  ALUSRCA,
  output logic [1:0]  ALUSRCB,
  output logic [1:0]  immSRC,
  output logic [2:0]  ALUControl,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    JAL      = 4'd9,
    BRANCH   = 4'd10,
    TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SLL = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  // raw write enables before the reset gate
  typedef struct packed {
    logic pc;
    logic ir;
    logic rf;
    logic mem;
  } we_t;

  state_t      cur, nxt;
  we_t         we;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic        func7;
  logic        taken;
  logic [2:0]  alu_op;
  logic        unused_instr;

  assign opcode       = instr[6:0];
  assign func3        = instr[14:12];
  assign func7        = instr[30];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  always_ff @(posedge clk or posedge areset) begin
    if (areset) cur <= FETCH;
    else        cur <= nxt;
  end

  // func7 only selects sub for register-register ops
  always_comb begin
    alu_op = ALU_ADD;
    unique case (func3)
      3'b000:  alu_op = (cur == EXECUTER && func7) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      3'b111:  alu_op = ALU_AND;
      default: alu_op = ALU_ADD;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    unique case (func3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = status_SF;
      3'b101:  taken = (ENABLE_BGEU != 0) && !status_SF;
      3'b110:  taken = (ENABLE_BGEU != 0) && status_CF;
      3'b111:  taken = (ENABLE_BGEU != 0) && !status_CF;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    immSRC = 2'b00;
    unique case (opcode)
      OP_STORE:  immSRC = 2'b01;
      OP_BRANCH: immSRC = 2'b10;
      OP_JAL:    immSRC = 2'b11;
      default:   immSRC = 2'b00;
    endcase
  end

  always_comb begin
    nxt        = cur;
    we         = '0;
    AdrSrc     = 1'b0;
    illegal    = 1'b0;
    ResultSRC  = 2'b00;
    ALUSRCA    = 2'b00;
    ALUSRCB    = 2'b00;
    ALUControl = ALU_ADD;
    unique case (cur)
      FETCH: begin
        ALUSRCB   = 2'b10;
        ResultSRC = 2'b10;
        we.ir     = mem_ready;
        we.pc     = mem_ready;
        if (mem_ready) nxt = DECODE;
      end
      DECODE: begin
        ALUSRCA = 2'b01;
        ALUSRCB = 2'b01;
        unique case (opcode)
          OP_LOAD, OP_STORE: nxt = MEMADR;
          OP_RTYPE:          nxt = EXECUTER;
          OP_ITYPE:          nxt = EXECUTEI;
          OP_BRANCH:         nxt = BRANCH;
          OP_JAL:            nxt = (ENABLE_JAL != 0) ? JAL : TRAP;
          default:           nxt = TRAP;
        endcase
      end
      MEMADR: begin
        ALUSRCA = 2'b10;
        ALUSRCB = 2'b01;
        nxt     = opcode[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) nxt = MEMWB;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        we.mem = 1'b1;
        if (mem_ready) nxt = FETCH;
      end
      MEMWB: begin
        ResultSRC = 2'b01;
        we.rf     = 1'b1;
        nxt       = FETCH;
      end
      EXECUTER, EXECUTEI: begin
        ALUSRCA    = 2'b10;
        ALUSRCB    = (cur == EXECUTEI) ? 2'b01 : 2'b00;
        ALUControl = alu_op;
        nxt        = ALUWB;
      end
      ALUWB: begin
        we.rf = 1'b1;
        nxt   = FETCH;
      end
      JAL: begin
        ALUSRCA = 2'b01;
        ALUSRCB = 2'b10;
        we.pc   = 1'b1;
        nxt     = ALUWB;
      end
      BRANCH: begin
        ALUSRCA    = 2'b10;
        ALUControl = ALU_SUB;
        we.pc      = taken;
        nxt        = FETCH;
      end
      TRAP: begin
        illegal = 1'b1;
        nxt     = TRAP;
      end
      default: nxt = FETCH;
    endcase
  end

  // enables are killed combinationally so an async reset aborts any pulse at once
  assign PCWrite  = we.pc  & ~areset;
  assign IRWrite  = we.ir  & ~areset;
  assign RegWrite = we.rf  & ~areset;
  assign memWrite = we.mem & ~areset;
  assign state    = cur;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: the driver pushes per-cycle expectations, a negedge monitor
// pops them and compares state, write enables, ALU op and immediate select.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        zero = 1'b0, status_SF = 1'b0, status_CF = 1'b0, mem_ready = 1'b0;
  logic        PCWrite, IRWrite, RegWrite, memWrite, AdrSrc, illegal;
  logic [1:0]  ResultSRC, ALUSRCA, ALUSRCB, immSRC;
  logic [2:0]  ALUControl;
  logic [3:0]  state;

  multicycle_control_unit #(.ENABLE_JAL(1), .ENABLE_BGEU(1)) dut (
    .clk(clk), .areset(areset), .instr(instr), .zero(zero),
    .status_SF(status_SF), .status_CF(status_CF), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .memWrite(memWrite),
    .AdrSrc(AdrSrc), .illegal(illegal), .ResultSRC(ResultSRC), .ALUSRCA(ALUSRCA),
    .ALUSRCB(ALUSRCB), .immSRC(immSRC), .ALUControl(ALUControl), .state(state)
  );

  always #5 clk = ~clk;

  // en = {PCWrite, IRWrite, RegWrite, memWrite, illegal}
  typedef struct packed {
    logic [3:0] st;
    logic [4:0] en;
    logic [2:0] aluc;
    logic [1:0] imm;
  } exp_t;

  exp_t       sbq[$];
  exp_t       me;
  logic [1:0] cur_imm = 2'b00;
  int         nchk = 0;
  int         nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      me = sbq.pop_front();
      chk("state", 32'(state), 32'(me.st));
      chk("enables", 32'({PCWrite, IRWrite, RegWrite, memWrite, illegal}), 32'(me.en));
      chk("aluctl", 32'(ALUControl), 32'(me.aluc));
      chk("immsrc", 32'(immSRC), 32'(me.imm));
    end
  end

  // one clock: drive inputs, queue what this cycle must look like, advance
  task automatic cyc(input logic mr, input logic [3:0] st, input logic [4:0] en,
                     input logic [2:0] aluc);
    mem_ready = mr;
    sbq.push_back('{st: st, en: en, aluc: aluc, imm: cur_imm});
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [31:0] i, input logic [1:0] imm);
    instr   = i;
    cur_imm = imm;
  endtask

  logic [2:0] alu_tab [8] = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b100, 3'b101, 3'b110, 3'b111};
  // {func3, zero, SF, CF, taken}
  logic [6:0] br_tab [14] = '{
    {3'b000, 3'b100, 1'b1}, {3'b001, 3'b100, 1'b0}, {3'b110, 3'b100, 1'b0},
    {3'b000, 3'b000, 1'b0}, {3'b001, 3'b000, 1'b1}, {3'b100, 3'b010, 1'b1},
    {3'b100, 3'b000, 1'b0}, {3'b101, 3'b000, 1'b1}, {3'b101, 3'b010, 1'b0},
    {3'b110, 3'b001, 1'b1}, {3'b111, 3'b000, 1'b1}, {3'b111, 3'b001, 1'b0},
    {3'b010, 3'b111, 1'b0}, {3'b011, 3'b111, 1'b0}};

  initial begin
    logic [6:0] b;
    @(posedge clk);
    #1;
    // reset: FETCH, enables held low even with mem_ready high
    set_instr(32'h002081B3, 2'b00);
    cyc(1'b1, 4'd0, 5'b00000, 3'b000);
    areset = 1'b0;

    // add x3,x1,x2
    cyc(1'b1, 4'd0, 5'b11000, 3'b000);
    cyc(1'b1, 4'd1, 5'b00000, 3'b000);
    cyc(1'b1, 4'd6, 5'b00000, 3'b000);
    cyc(1'b1, 4'd8, 5'b00100, 3'b000);

    // sub x2,x1,x2
    set_instr(32'h40208133, 2'b00);
    cyc(1'b1, 4'd0, 5'b11000, 3'b000);
    cyc(1'b1, 4'd1, 5'b00000, 3'b000);
    cyc(1'b1, 4'd6, 5'b00000, 3'b010);
    cyc(1'b1, 4'd8, 5'b00100, 3'b000);

    // R-type and I-type ALU decode; bit30 set on I-type must not give sub
    for (int i = 0; i < 8; i++) begin
      set_instr(32'h00208033 | (32'(i) << 12), 2'b00);
      cyc(1'b1, 4'd0, 5'b11000, 3'b000);
      cyc(1'b1, 4'd1, 5'b00000, 3'b000);
      cyc(1'b1, 4'd6, 5'b00000, alu_tab[i]);
      cyc(1'b1, 4'd8, 5'b00100, 3'b000);
      set_instr(32'h40000093 | (32'(i) << 12), 2'b00);
      cyc(1'b1, 4'd0, 5'b11000, 3'b000);
      cyc(1'b1, 4'd1, 5'b00000, 3'b000);
      cyc(1'b1, 4'd7, 5'b00000, alu_tab[i]);
      cyc(1'b1, 4'd8, 5'b00100, 3'b000);
    end

    // lw with 2 fetch stalls and 3 memread stalls: 10 cycles
    set_instr(32'h0000A183, 2'b00);
    cyc(1'b0, 4'd0, 5'b00000, 3'b000);
    cyc(1'b0, 4'd0, 5'b00000, 3'b000);
    cyc(1'b1, 4'd0, 5'b11000, 3'b000);
    cyc(1'b1, 4'd1, 5'b00000, 3'b000);
    cyc(1'b1, 4'd2, 5'b00000, 3'b000);
    cyc(1'b0, 4'd3, 5'b00000, 3'b000);
    cyc(1'b0, 4'd3, 5'b00000, 3'b000);
    cyc(1'b0, 4'd3, 5'b00000, 3'b000);
    cyc(1'b1, 4'd3, 5'b00000, 3'b000);
    cyc(1'b1, 4'd4, 5'b00100, 3'b000);

    // sw with one memwrite stall
    set_instr(32'h0020A223, 2'b01);
    cyc(1'b1, 4'd0, 5'b11000, 3'b000);
    cyc(1'b1, 4'd1, 5'b00000, 3'b000);
    cyc(1'b1, 4'd2, 5'b00000, 3'b000);
    cyc(1'b0, 4'd5, 5'b00010, 3'b000);
    cyc(1'b1, 4'd5, 5'b00010, 3'b000);

    // branches across all func3/flag combinations
    for (int i = 0; i < 14; i++) begin
      b = br_tab[i];
      set_instr(32'h00208063 | (32'(b[6:4]) << 12), 2'b10);
      zero = b[3]; status_SF = b[2]; status_CF = b[1];
      cyc(1'b1, 4'd0, 5'b11000, 3'b000);
      cyc(1'b1, 4'd1, 5'b00000, 3'b000);
      cyc(1'b1, 4'd10, {b[0], 4'b0000}, 3'b010);
    end

    // jal
    set_instr(32'h008000EF, 2'b11);
    cyc(1'b1, 4'd0, 5'b11000, 3'b000);
    cyc(1'b1, 4'd1, 5'b00000, 3'b000);
    cyc(1'b1, 4'd9, 5'b10000, 3'b000);
    cyc(1'b1, 4'd8, 5'b00100, 3'b000);

    // illegal opcode traps and sticks, even with mem_ready toggling
    set_instr(32'h00000000, 2'b00);
    cyc(1'b1, 4'd0, 5'b11000, 3'b000);
    cyc(1'b1, 4'd1, 5'b00000, 3'b000);
    for (int i = 0; i < 20; i++) cyc(1'(i % 2), 4'd11, 5'b00001, 3'b000);
    areset = 1'b1;
    cyc(1'b1, 4'd0, 5'b00000, 3'b000);
    areset = 1'b0;

    // reset in the middle of a stalled store
    set_instr(32'h0020A223, 2'b01);
    cyc(1'b1, 4'd0, 5'b11000, 3'b000);
    cyc(1'b1, 4'd1, 5'b00000, 3'b000);
    cyc(1'b1, 4'd2, 5'b00000, 3'b000);
    cyc(1'b0, 4'd5, 5'b00010, 3'b000);
    areset = 1'b1;
    #1;
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_memwrite", 32'(memWrite), 32'd0);
    cyc(1'b1, 4'd0, 5'b00000, 3'b000);
    areset = 1'b0;
    set_instr(32'h002081B3, 2'b00);
    cyc(1'b1, 4'd0, 5'b11000, 3'b000);
    cyc(1'b1, 4'd1, 5'b00000, 3'b000);

    @(negedge clk);
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
